// File: rtl/vedic_mac_acc.sv
// Multiply-accumulate back end for the 16x16 Vedic multiplier: sums a burst of
// unsigned products over a valid/ready handshake and pulses done with the result.
module vedic_mac_acc #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic             xfer;
  logic             last;
  logic [ACC_W:0]   sum;

  assign xfer = prod_valid && prod_ready;
  assign last = (count == len_q - LEN_W'(1));
  // One extra bit captures the carry out of bit ACC_W-1 for the overflow flag.
  assign sum  = {1'b0, acc_out} + (ACC_W + 1)'(prod);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: defaulting every always_comb output up front keeps paths that do not
  // assign it from inferring a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (len == '0) ? DONE : ACC;
      ACC:  if (xfer && last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    prod_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ACC: begin
        prod_ready = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // acc_out and ovf persist through IDLE so the last burst result stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out <= '0;
      ovf     <= 1'b0;
      count   <= '0;
      len_q   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc_out <= '0;
          ovf     <= 1'b0;
          count   <= '0;
          len_q   <= len;
        end
        ACC: if (xfer) begin
          acc_out <= sum[ACC_W-1:0];
          count   <= count + LEN_W'(1);
          if (sum[ACC_W]) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_mac_acc.sv
// Directed bench for vedic_mac_acc: a 40-bit and a 33-bit instance share stimulus
// so the same overflow burst shows wrap and no-wrap behaviour side by side.
module tb_vedic_mac_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        prod_valid;
  logic [31:0] prod;

  logic        prod_ready, busy, done, ovf;
  logic [39:0] acc_out;
  logic        prod_ready33, busy33, done33, ovf33;
  logic [32:0] acc_out33;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  vedic_mac_acc dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready),
    .acc_out(acc_out), .busy(busy), .done(done), .ovf(ovf)
  );

  vedic_mac_acc #(.PROD_W(32), .ACC_W(33), .LEN_W(8)) dut33 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready33),
    .acc_out(acc_out33), .busy(busy33), .done(done33), .ovf(ovf33)
  );

  always #5 clk = ~clk;

  // done seen at a rising edge is the value held during the cycle just ending.
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic rdy, input logic bsy, input logic dn);
    check({tag, ".prod_ready"}, 64'(prod_ready), 64'(rdy));
    check({tag, ".busy"},       64'(busy),       64'(bsy));
    check({tag, ".done"},       64'(done),       64'(dn));
  endtask

  // All input changes and output samples happen on the falling edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] p);
    prod_valid = 1'b1;
    prod       = p;
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  int base;

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0;
    idle(2);
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check("reset.acc", 64'(acc_out), 64'h0);
    check("reset.ovf", 64'(ovf), 64'h0);
    rst = 1'b0;
    idle(1);

    // Basic burst 1,2,3,4 back-to-back.
    do_start(8'd4);
    check_ctl("basic.t1", 1'b1, 1'b1, 1'b0);
    feed(32'd1); check("basic.acc1", 64'(acc_out), 64'd1);
    feed(32'd2); check("basic.acc2", 64'(acc_out), 64'd3);
    feed(32'd3); check("basic.acc3", 64'(acc_out), 64'd6);
    feed(32'd4);
    check_ctl("basic.done", 1'b0, 1'b1, 1'b1);
    check("basic.acc", 64'(acc_out), 64'd10);
    check("basic.ovf", 64'(ovf), 64'h0);
    idle(1);
    check_ctl("basic.idle", 1'b0, 1'b0, 1'b0);
    check("basic.hold", 64'(acc_out), 64'd10);

    // Valid gaps of two cycles between transfers.
    do_start(8'd3);
    feed(32'h0000_FFFF);
    idle(2);
    check_ctl("gap.wait", 1'b1, 1'b1, 1'b0);
    check("gap.acc1", 64'(acc_out), 64'h0FFFF);
    feed(32'h0001_0000);
    idle(2);
    check("gap.acc2", 64'(acc_out), 64'h1FFFF);
    feed(32'h0000_0001);
    check_ctl("gap.done", 1'b0, 1'b1, 1'b1);
    check("gap.acc", 64'(acc_out), 64'h20000);
    check("gap.acc33", 64'(acc_out33), 64'h20000);
    idle(1);
    check_ctl("gap.idle", 1'b0, 1'b0, 1'b0);

    // Zero-length burst finishes in one cycle without ever asking for a product.
    do_start(8'd0);
    check_ctl("zero.done", 1'b0, 1'b1, 1'b1);
    check("zero.acc", 64'(acc_out), 64'h0);
    idle(1);
    check_ctl("zero.idle", 1'b0, 1'b0, 1'b0);

    // Overflow: three max products; wraps at 33 bits, fits in 40 bits.
    do_start(8'd3);
    feed(32'hFFFF_FFFF);
    feed(32'hFFFF_FFFF);
    check("ovf.acc33_2", 64'(acc_out33), 64'h1_FFFF_FFFE);
    check("ovf.ovf33_2", 64'(ovf33), 64'h0);
    feed(32'hFFFF_FFFF);
    check("ovf.done33", 64'(done33), 64'h1);
    check("ovf.acc33_3", 64'(acc_out33), 64'h0_FFFF_FFFD);
    check("ovf.ovf33_3", 64'(ovf33), 64'h1);
    check("ovf.acc40", 64'(acc_out), 64'h2_FFFF_FFFD);
    check("ovf.ovf40", 64'(ovf), 64'h0);
    idle(1);
    check("ovf.sticky", 64'(ovf33), 64'h1);
    do_start(8'd1);
    check("ovf.clear", 64'(ovf33), 64'h0);
    check("ovf.clear_acc", 64'(acc_out33), 64'h0);
    feed(32'd2);
    check("ovf.next", 64'(acc_out33), 64'd2);
    idle(1);

    // Reset in the middle of a burst discards the partial sum.
    do_start(8'd5);
    feed(32'd7);
    feed(32'd7);
    check("rstmid.acc", 64'(acc_out), 64'd14);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_ctl("rstmid.after", 1'b0, 1'b0, 1'b0);
    check("rstmid.acc0", 64'(acc_out), 64'h0);
    idle(1);
    check_ctl("rstmid.still", 1'b0, 1'b0, 1'b0);
    do_start(8'd1);
    feed(32'd9);
    check_ctl("rstmid.done", 1'b0, 1'b1, 1'b1);
    check("rstmid.acc9", 64'(acc_out), 64'd9);
    idle(1);

    // start held during ACC and DONE of a len=2 burst is ignored.
    base = done_cnt;
    do_start(8'd2);
    start = 1'b1;
    len   = 8'd1;
    feed(32'd5);
    check_ctl("ign.acc", 1'b1, 1'b1, 1'b0);
    check("ign.acc5", 64'(acc_out), 64'd5);
    feed(32'd6);
    check_ctl("ign.done", 1'b0, 1'b1, 1'b1);
    check("ign.acc11", 64'(acc_out), 64'd11);
    idle(1);
    start = 1'b0;
    check_ctl("ign.idle", 1'b0, 1'b0, 1'b0);
    check("ign.hold", 64'(acc_out), 64'd11);
    idle(3);
    check_ctl("ign.stay", 1'b0, 1'b0, 1'b0);
    check("ign.pulses", 64'(done_cnt - base), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
